// File: rtl/hangy_input_frontend.sv
// Button front end for the hangy core: synchronize, debounce, step the letter, snapshot a word index.
// Optional auto-repeat of held up/down buttons is enabled by defining HANGY_AUTOREPEAT_EN.
module hangy_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LETTERS         = 26,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int REPEAT_CYCLES   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  output logic [11:0] chip_input,
  output logic        busy
);

  localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W    = $clog2(HOLDOFF_CYCLES);
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_ENTER = 2;

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {btn_enter, btn_down, btn_up};

  // Per button: 2-flop synchronizer, stability counter, and a delayed copy for edge detection.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic [DEB_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta_reg    <= 1'b0;
        sync_reg    <= 1'b0;
        level_reg   <= 1'b0;
        level_d_reg <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        meta_reg    <= raw[gi];
        sync_reg    <= meta_reg;
        level_d_reg <= level_reg;
        if (sync_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_W'(DEBOUNCE_CYCLES)) begin
          level_reg <= sync_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign press[gi] = level_reg & ~level_d_reg;
  end

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [4:0]        letter_reg, letter_next;
  logic [5:0]        word_reg, word_next;
  logic [5:0]        lfsr_reg;
  logic              next_reg;
  logic              busy_reg;
  logic              step_up;
  logic              step_down;

`ifdef HANGY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             rpt_hold;
  logic             rpt_fire;

  // Exactly one of up/down held in IDLE; both held cancels repeating.
  assign rpt_hold = (state_reg == IDLE) && (g_btn[BTN_UP].level_reg ^ g_btn[BTN_DOWN].level_reg);
  assign rpt_fire = rpt_hold && (rpt_cnt_reg == RPT_W'(REPEAT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_reg <= '0;
    end else if (!rpt_hold) begin
      rpt_cnt_reg <= '0;
    end else if (rpt_fire) begin
      rpt_cnt_reg <= RPT_W'(1);
    end else begin
      rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
    end
  end

  assign step_up   = press[BTN_UP]   | (rpt_fire & g_btn[BTN_UP].level_reg);
  assign step_down = press[BTN_DOWN] | (rpt_fire & g_btn[BTN_DOWN].level_reg);
`else
  logic unused_repeat;

  assign unused_repeat = (REPEAT_CYCLES > 0);
  assign step_up       = press[BTN_UP];
  assign step_down     = press[BTN_DOWN];
`endif

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    letter_next   = letter_reg;
    word_next     = word_reg;
    case (state_reg)
      IDLE: begin
        if (press[BTN_ENTER]) begin
          state_next = PULSE;
          word_next  = lfsr_reg - 6'd1;
        end else if (step_up && !step_down) begin
          letter_next = (letter_reg == 5'(LETTERS - 1)) ? 5'd0 : letter_reg + 5'd1;
        end else if (step_down && !step_up) begin
          letter_next = (letter_reg == 5'd0) ? 5'(LETTERS - 1) : letter_reg - 5'd1;
        end
      end
      PULSE: begin
        state_next    = HOLDOFF;
        hold_cnt_next = HOLD_W'(HOLDOFF_CYCLES - 1);
      end
      HOLDOFF: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe and busy are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      letter_reg   <= '0;
      word_reg     <= '0;
      lfsr_reg     <= 6'b000001;
      next_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      letter_reg   <= letter_next;
      word_reg     <= word_next;
      lfsr_reg     <= {lfsr_reg[4:0], lfsr_reg[5] ^ lfsr_reg[4]};
      next_reg     <= (state_next == PULSE);
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign chip_input = {word_reg, next_reg, letter_reg};
  assign busy       = busy_reg;

endmodule

// File: tb/tb_hangy_input_frontend.sv
// Directed bench for hangy_input_frontend; strobes and letter steps are predicted into queues
// and matched by a monitor when the DUT produces them.
module tb_hangy_input_frontend;
  localparam int D = 16;
  localparam int L = 26;
  localparam int H = 48;
  localparam int R = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_enter = 1'b0;
  logic [11:0] chip_input;
  logic        busy;

  always #5 clk = ~clk;

  hangy_input_frontend #(
    .DEBOUNCE_CYCLES(D),
    .LETTERS(L),
    .HOLDOFF_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_enter(btn_enter),
    .chip_input(chip_input),
    .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 6'b000001;
    else      m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
  end

  function automatic logic [5:0] lfsr_adv(input logic [5:0] q, input int n);
    logic [5:0] r = q;
    for (int i = 0; i < n; i++) r = {r[4:0], r[5] ^ r[4]};
    return r;
  endfunction

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {int cyc; logic [5:0] word; logic [4:0] letter;} strobe_t;
  typedef struct {int cyc; logic [4:0] letter;} step_t;
  strobe_t sq[$];
  step_t   lq[$];
  strobe_t se;
  step_t   le;

  task automatic push_strobe(input int c, input logic [5:0] w, input logic [4:0] l);
    strobe_t e;
    e.cyc = c; e.word = w; e.letter = l;
    sq.push_back(e);
  endtask

  task automatic push_letter(input int c, input logic [4:0] l);
    step_t e;
    e.cyc = c; e.letter = l;
    lq.push_back(e);
  endtask

  // Monitor: every strobe and every letter change must match the head of its queue.
  logic [4:0] prev_letter = '0;
  logic [5:0] prev_word = '0;
  logic       prev_next = 1'b0;
  int         last_strobe = -1;

  always @(negedge clk) begin
    if (!rst) begin
      prev_letter = '0;
      prev_word   = '0;
      prev_next   = 1'b0;
      last_strobe = -1;
    end else begin
      if (chip_input[5]) begin
        if (sq.size() == 0) begin
          chk("unexpected_next", chip_input[5], 1'b0);
        end else begin
          se = sq.pop_front();
          $display("strobe at cycle %0d word=%0d letter=%0d", cyc, chip_input[11:6], chip_input[4:0]);
          chk("next_cycle", cyc, se.cyc);
          chk("next_word", chip_input[11:6], se.word);
          chk("next_letter", chip_input[4:0], se.letter);
          chk("next_busy", busy, 1'b1);
        end
        if (last_strobe >= 0) chk("strobe_spacing", (cyc - last_strobe) >= H + 1, 1'b1);
        last_strobe = cyc;
      end
      if (prev_next) begin
        chk("hold_letter", chip_input[4:0], prev_letter);
        chk("hold_word", chip_input[11:6], prev_word);
      end
      if (chip_input[4:0] !== prev_letter) begin
        if (lq.size() == 0) begin
          chk("unexpected_letter", chip_input[4:0], prev_letter);
        end else begin
          le = lq.pop_front();
          $display("letter step at cycle %0d -> %0d", cyc, chip_input[4:0]);
          chk("letter_cycle", cyc, le.cyc);
          chk("letter_value", chip_input[4:0], le.letter);
        end
      end
      prev_letter = chip_input[4:0];
      prev_word   = chip_input[11:6];
      prev_next   = chip_input[5];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic wait_strobe(input int limit);
    int n = 0;
    @(negedge clk);
    while (!chip_input[5] && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", chip_input[5], 1'b1);
  endtask

  // One letter button press: hold long enough to debounce, then release and let it settle.
  task automatic press_letter(input logic up, input logic dn, input logic expect_step, input logic [4:0] exp);
    int c0;
    tick(1);
    c0 = cyc;
    btn_up = up;
    btn_down = dn;
    if (expect_step) push_letter(c0 + D + 4, exp);
    tick(D + 8);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(D + 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;

    // Reset state and LFSR sequence after release.
    tick(3);
    chk("reset_chip_input", chip_input, 12'h000);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("lfsr_first", dut.lfsr_reg, 6'b000010);
    repeat (62) begin
      @(negedge clk);
      chk("lfsr_model", dut.lfsr_reg, m_lfsr);
      chk("lfsr_nonzero", dut.lfsr_reg != 6'd0, 1'b1);
    end

    // Bouncy up press: 10 high, 3 low, then a stable run that yields one step.
    tick(1);
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(3);
    btn_up = 1'b1;
    c1 = cyc;
    push_letter(c1 + D + 4, 5'd1);
    tick(20);
    btn_up = 1'b0;
    tick(D + 8);
    chk("debounce_letter", chip_input[4:0], 5'd1);

    // Wrap both directions from a fresh reset; simultaneous press does nothing.
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    press_letter(1'b0, 1'b1, 1'b1, 5'd25);
    press_letter(1'b1, 1'b0, 1'b1, 5'd0);
    press_letter(1'b1, 1'b1, 1'b0, 5'd0);
    chk("both_pressed_letter", chip_input[4:0], 5'd0);
    press_letter(1'b1, 1'b0, 1'b1, 5'd1);
    press_letter(1'b1, 1'b0, 1'b1, 5'd2);

    // Enter capture, a discarded press during hold-off, then an accepted press.
    tick(1);
    c0 = cyc;
    btn_enter = 1'b1;
    push_strobe(c0 + D + 4, lfsr_adv(m_lfsr, D + 3) - 6'd1, 5'd2);
    wait_strobe(D + 10);
    wait_to(c0 + 22);
    chk("holdoff_busy_early", busy, 1'b1);
    btn_enter = 1'b0;
    wait_to(c0 + 43);
    btn_enter = 1'b1;
    wait_to(c0 + 62);
    @(negedge clk);
    chk("holdoff_press_level", dut.g_btn[2].level_reg, 1'b1);
    chk("holdoff_busy", busy, 1'b1);
    wait_to(c0 + 65);
    btn_enter = 1'b0;
    wait_to(c0 + 72);
    chk("busy_released", busy, 1'b0);
    wait_to(c0 + 86);
    btn_enter = 1'b1;
    push_strobe(c0 + 106, lfsr_adv(m_lfsr, D + 3) - 6'd1, 5'd2);
    wait_strobe(D + 10);
    tick(3);
    btn_enter = 1'b0;
    tick(D + H + 10);

    // Reset asserted in the middle of a strobe.
    tick(1);
    c0 = cyc;
    btn_enter = 1'b1;
    push_strobe(c0 + D + 4, lfsr_adv(m_lfsr, D + 3) - 6'd1, 5'd2);
    wait_strobe(D + 10);
    #2;
    rst = 1'b0;
    #1;
    chk("midpulse_chip_input", chip_input, 12'h000);
    chk("midpulse_busy", busy, 1'b0);
    btn_enter = 1'b0;
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("lfsr_after_rerelease", dut.lfsr_reg, 6'b000010);

    // Held up button: one step, plus repeats when auto-repeat is built in.
    tick(1);
    c0 = cyc;
    btn_up = 1'b1;
    push_letter(c0 + D + 4, 5'd1);
`ifdef HANGY_AUTOREPEAT_EN
    push_letter(c0 + D + 4 + R, 5'd2);
    push_letter(c0 + D + 4 + 2 * R, 5'd3);
    push_letter(c0 + D + 4 + 3 * R, 5'd4);
`endif
    wait_to(c0 + D + 4 + 100);
    btn_up = 1'b0;
    wait_to(c0 + 170);
`ifdef HANGY_AUTOREPEAT_EN
    chk("held_letter", chip_input[4:0], 5'd4);
`else
    chk("held_letter", chip_input[4:0], 5'd1);
`endif

    chk("strobe_queue_drained", sq.size(), 0);
    chk("letter_queue_drained", lq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
